// File: rtl/vga_frame_checker_if.sv
// Pixel tap between the VGA controller and the pins.
//   frame_start  one-cycle pulse at the start of a frame (Vsync falling edge)
//   pixel_valid  pixel_x/pixel_y/red/green/blue are valid this cycle
//   pixel_x/y    pixel column/row
//   red/green/blue observed colour, COLOR_W bits per channel
// master: pixel source side; slave: checker side.
interface vga_frame_checker_if #(
  parameter int COLOR_W = 8
);
  logic               frame_start;
  logic               pixel_valid;
  logic [9:0]         pixel_x;
  logic [9:0]         pixel_y;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;

  modport master (output frame_start, pixel_valid, pixel_x, pixel_y, red, green, blue);
  modport slave  (input  frame_start, pixel_valid, pixel_x, pixel_y, red, green, blue);
endinterface

// File: rtl/vga_frame_checker.sv
// On-chip checker for one frame of the rectangle test pattern. Computes the
// expected colour of every pixel inside the view window, counts mismatching
// channels, latches the first failing pixel and optionally stops at a limit.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse: arm for the next frame
//   mode            0 diag, 1 checker, 2 vbars, 3 hbars
//   pix             pixel tap (slave modport)
//   busy, done      status (ARMED/CHECK/DRAIN, DONE)
//   limit_hit       check stopped by MISMATCH_LIMIT
//   mismatch_count  saturating count of mismatching channels
//   first_err_*     location of the first mismatching pixel
//
// state | meaning
// IDLE  | waiting for start
// ARMED | waiting for frame_start
// CHECK | comparing pixels of the frame
// DRAIN | letting the two-stage pipeline empty (2 cycles)
// DONE  | results stable until next start
module vga_frame_checker #(
  parameter int VIEW_LEFT      = 160,
  parameter int VIEW_TOP       = 120,
  parameter int VIEW_WIDTH     = 320,
  parameter int VIEW_HEIGHT    = 240,
  parameter int RECT_WIDTH     = 40,
  parameter int RECT_HEIGHT    = 30,
  parameter int COLOR_W        = 8,
  parameter int MISMATCH_LIMIT = 20,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  vga_frame_checker_if.slave   pix,
  output logic                 busy,
  output logic                 done,
  output logic                 limit_hit,
  output logic [CNT_W-1:0]     mismatch_count,
  output logic                 first_err_valid,
  output logic [9:0]           first_err_x,
  output logic [9:0]           first_err_y
);
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CHECK, S_DRAIN, S_DONE} state_t;

  localparam logic [10:0]      X_LO    = 11'(VIEW_LEFT);
  localparam logic [10:0]      X_HI    = 11'(VIEW_LEFT + VIEW_WIDTH);
  localparam logic [10:0]      Y_LO    = 11'(VIEW_TOP);
  localparam logic [10:0]      Y_HI    = 11'(VIEW_TOP + VIEW_HEIGHT);
  localparam logic [9:0]       RW_M1   = 10'(RECT_WIDTH - 1);
  localparam logic [9:0]       RH_M1   = 10'(RECT_HEIGHT - 1);
  localparam logic [31:0]      LIMIT32 = 32'(MISMATCH_LIMIT);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  state_t state, state_nxt;

  // Rectangle indices only need 3 bits: the colour index is taken mod 8.
  logic [9:0] col_sub, row_sub, last_x, last_y;
  logic [2:0] cidx, ridx;
  logic [1:0] mode_q;
  logic       drain_cnt;

  logic [9:0] col_sub_cur, row_sub_cur;
  logic [2:0] cidx_cur, ridx_cur, c_cur;
  logic       in_view, accept, lim_now, clear_run;

  logic               s1_valid;
  logic [9:0]         s1_x, s1_y;
  logic [COLOR_W-1:0] s1_r, s1_g, s1_b;
  logic [2:0]         s1_c;

  logic [1:0]         n_mis;
  logic [CNT_W+1:0]   cnt_sum;
  logic [CNT_W-1:0]   cnt_next;

  // Stage 2 compare, saturating count, limit detect.
  always_comb begin
    n_mis    = {1'b0, s1_r != {COLOR_W{s1_c[2]}}}
             + {1'b0, s1_g != {COLOR_W{s1_c[1]}}}
             + {1'b0, s1_b != {COLOR_W{s1_c[0]}}};
    cnt_sum  = (CNT_W+2)'(mismatch_count) + (CNT_W+2)'(n_mis);
    cnt_next = (cnt_sum > {2'b00, CNT_SAT}) ? CNT_SAT : cnt_sum[CNT_W-1:0];
    lim_now  = (LIMIT32 != 32'd0) && (state == S_CHECK) && s1_valid
               && (32'(cnt_next) >= LIMIT32);
  end

  // Raster-order rectangle tracking; repeated X/Y leaves counters untouched.
  always_comb begin
    in_view = ({1'b0, pix.pixel_x} >= X_LO) && ({1'b0, pix.pixel_x} < X_HI)
           && ({1'b0, pix.pixel_y} >= Y_LO) && ({1'b0, pix.pixel_y} < Y_HI);
    // Once the limit is reached nothing new enters the pipeline.
    accept  = (state == S_CHECK) && pix.pixel_valid && in_view && !lim_now;

    col_sub_cur = col_sub;
    cidx_cur    = cidx;
    if ({1'b0, pix.pixel_x} == X_LO) begin
      col_sub_cur = '0;
      cidx_cur    = '0;
    end else if (!(pix.pixel_x == last_x && pix.pixel_y == last_y)) begin
      if (col_sub == RW_M1) begin
        col_sub_cur = '0;
        cidx_cur    = cidx + 3'd1;
      end else begin
        col_sub_cur = col_sub + 10'd1;
      end
    end

    row_sub_cur = row_sub;
    ridx_cur    = ridx;
    if ({1'b0, pix.pixel_y} == Y_LO) begin
      row_sub_cur = '0;
      ridx_cur    = '0;
    end else if (pix.pixel_y != last_y) begin
      if (row_sub == RH_M1) begin
        row_sub_cur = '0;
        ridx_cur    = ridx + 3'd1;
      end else begin
        row_sub_cur = row_sub + 10'd1;
      end
    end

    case (mode_q)
      2'd0:    c_cur = cidx_cur + ridx_cur;
      2'd1:    c_cur = (cidx_cur[0] ^ ridx_cur[0]) ? 3'd7 : 3'd0;
      2'd2:    c_cur = cidx_cur;
      default: c_cur = ridx_cur;
    endcase
  end

  always_comb begin
    state_nxt = state;
    clear_run = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          state_nxt = S_ARMED;
          clear_run = 1'b1;
        end
      end
      S_ARMED: begin
        busy = 1'b1;
        if (pix.frame_start) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (pix.frame_start || lim_now) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt       <= 1'b0;
      mode_q          <= '0;
      last_x          <= '0;
      last_y          <= '0;
      col_sub         <= '0;
      row_sub         <= '0;
      cidx            <= '0;
      ridx            <= '0;
      s1_valid        <= 1'b0;
      s1_x            <= '0;
      s1_y            <= '0;
      s1_r            <= '0;
      s1_g            <= '0;
      s1_b            <= '0;
      s1_c            <= '0;
      mismatch_count  <= '0;
      first_err_valid <= 1'b0;
      first_err_x     <= '0;
      first_err_y     <= '0;
      limit_hit       <= 1'b0;
    end else begin
      drain_cnt <= (state == S_DRAIN);
      if (state == S_ARMED && pix.frame_start) begin
        mode_q  <= mode;
        last_x  <= '0;
        last_y  <= '0;
        col_sub <= '0;
        row_sub <= '0;
        cidx    <= '0;
        ridx    <= '0;
      end
      s1_valid <= accept;
      if (accept) begin
        last_x  <= pix.pixel_x;
        last_y  <= pix.pixel_y;
        col_sub <= col_sub_cur;
        row_sub <= row_sub_cur;
        cidx    <= cidx_cur;
        ridx    <= ridx_cur;
        s1_x    <= pix.pixel_x;
        s1_y    <= pix.pixel_y;
        s1_r    <= pix.red;
        s1_g    <= pix.green;
        s1_b    <= pix.blue;
        s1_c    <= c_cur;
      end
      if (clear_run) begin
        s1_valid        <= 1'b0;
        mismatch_count  <= '0;
        first_err_valid <= 1'b0;
        first_err_x     <= '0;
        first_err_y     <= '0;
        limit_hit       <= 1'b0;
      end else if (s1_valid) begin
        mismatch_count <= cnt_next;
        if (n_mis != 2'd0 && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_x     <= s1_x;
          first_err_y     <= s1_y;
        end
        if (lim_now) limit_hit <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_frame_checker.sv
// Directed bench on a small 12x6 view (left 4, top 2) inside a 20x10 raster.
// dut_a: 3x2 rectangles, limit 20. dut_b: 1-pixel-wide rectangles, no limit.
// dut_c: as dut_a but 4-bit counter and no limit.
module tb_vga_frame_checker;
  logic clk = 1'b0;
  logic rst, start;
  logic [1:0] mode;
  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  vga_frame_checker_if #(.COLOR_W(8)) pif ();

  logic busy_a, done_a, lim_a, fev_a;
  logic [15:0] cnt_a;
  logic [9:0] fx_a, fy_a;
  logic busy_b, done_b, lim_b, fev_b;
  logic [15:0] cnt_b;
  logic [9:0] fx_b, fy_b;
  logic busy_c, done_c, lim_c, fev_c;
  logic [3:0] cnt_c;
  logic [9:0] fx_c, fy_c;

  vga_frame_checker #(.VIEW_LEFT(4), .VIEW_TOP(2), .VIEW_WIDTH(12), .VIEW_HEIGHT(6),
    .RECT_WIDTH(3), .RECT_HEIGHT(2), .COLOR_W(8), .MISMATCH_LIMIT(20), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pix(pif),
    .busy(busy_a), .done(done_a), .limit_hit(lim_a), .mismatch_count(cnt_a),
    .first_err_valid(fev_a), .first_err_x(fx_a), .first_err_y(fy_a));

  vga_frame_checker #(.VIEW_LEFT(4), .VIEW_TOP(2), .VIEW_WIDTH(12), .VIEW_HEIGHT(6),
    .RECT_WIDTH(1), .RECT_HEIGHT(2), .COLOR_W(8), .MISMATCH_LIMIT(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pix(pif),
    .busy(busy_b), .done(done_b), .limit_hit(lim_b), .mismatch_count(cnt_b),
    .first_err_valid(fev_b), .first_err_x(fx_b), .first_err_y(fy_b));

  vga_frame_checker #(.VIEW_LEFT(4), .VIEW_TOP(2), .VIEW_WIDTH(12), .VIEW_HEIGHT(6),
    .RECT_WIDTH(3), .RECT_HEIGHT(2), .COLOR_W(8), .MISMATCH_LIMIT(0), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pix(pif),
    .busy(busy_c), .done(done_c), .limit_hit(lim_c), .mismatch_count(cnt_c),
    .first_err_valid(fev_c), .first_err_x(fx_c), .first_err_y(fy_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected colour index for dut_a geometry, computed with division.
  function automatic logic [2:0] model_c(input logic [1:0] m, input int x, input int y);
    int cx, ry;
    cx = (x - 4) / 3;
    ry = (y - 2) / 2;
    case (m)
      2'd0:    return 3'((cx + ry) % 8);
      2'd1:    return (((cx ^ ry) & 1) != 0) ? 3'd7 : 3'd0;
      2'd2:    return 3'(cx % 8);
      default: return 3'(ry % 8);
    endcase
  endfunction

  task automatic set_pix(input logic v, input int x, input int y,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pif.pixel_valid = v;
    pif.pixel_x = 10'(x);
    pif.pixel_y = 10'(y);
    pif.red = r;
    pif.green = g;
    pif.blue = b;
  endtask

  task automatic arm(input logic with_fs);
    start = 1'b1;
    pif.frame_start = with_fs;
    tick();
    start = 1'b0;
    pif.frame_start = 1'b0;
  endtask

  // corrupt: 0 clean, 1 blue=0 at (7,3), 2 all channels inverted, 3 all black.
  task automatic send_frame(input logic [1:0] m, input int corrupt, input int rep,
                            input logic [1:0] m_late, output int lim_t, output int done_t);
    int t;
    logic [2:0] c;
    logic [7:0] r, g, b;
    t = 0;
    lim_t = -1;
    done_t = -1;
    mode = m;
    pif.pixel_valid = 1'b0;
    pif.frame_start = 1'b1;
    tick();
    pif.frame_start = 1'b0;
    for (int y = 0; y < 10; y++) begin
      for (int x = 0; x < 20; x++) begin
        c = (x >= 4 && x < 16 && y >= 2 && y < 8) ? model_c(m, x, y) : 3'd0;
        r = {8{c[2]}};
        g = {8{c[1]}};
        b = {8{c[0]}};
        if (corrupt == 1 && x == 7 && y == 3) b = 8'h00;
        if (corrupt == 2) begin
          r = ~r;
          g = ~g;
          b = ~b;
        end
        if (corrupt == 3) begin
          r = 8'h00;
          g = 8'h00;
          b = 8'h00;
        end
        for (int k = 0; k < rep; k++) begin
          set_pix(1'b1, x, y, r, g, b);
          tick();
          t++;
          if (lim_a && lim_t < 0) lim_t = t;
          if (done_a && done_t < 0) done_t = t;
        end
        if (y == 4) mode = m_late;
      end
    end
    pif.pixel_valid = 1'b0;
    pif.frame_start = 1'b1;
    tick();
    pif.frame_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (done_a && done_b && done_c) break;
      tick();
    end
  endtask

  initial begin
    int lt, dt;
    rst = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    pif.frame_start = 1'b0;
    set_pix(1'b0, 0, 0, 8'h00, 8'h00, 8'h00);
    repeat (3) tick();
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    check("reset_done", {31'd0, done_a}, 32'd0);
    check("reset_count", {16'd0, cnt_a}, 32'd0);
    check("reset_fev", {31'd0, fev_a}, 32'd0);
    rst = 1'b0;
    tick();

    // T1: clean mode0 frame, each pixel repeated, mode port changed mid-frame
    arm(1'b0);
    check("t1_busy_armed", {31'd0, busy_a}, 32'd1);
    send_frame(2'd0, 0, 2, 2'd3, lt, dt);
    check("t1_done", {31'd0, done_a}, 32'd1);
    check("t1_count", {16'd0, cnt_a}, 32'd0);
    check("t1_fev", {31'd0, fev_a}, 32'd0);
    check("t1_limit", {31'd0, lim_a}, 32'd0);
    check("t1_count_c", {28'd0, cnt_c}, 32'd0);

    // Start with frame_start in IDLE: armed only, bad pixels before next frame ignored
    arm(1'b1);
    check("arm_fs_busy", {31'd0, busy_a}, 32'd1);
    for (int x = 4; x < 9; x++) begin
      set_pix(1'b1, x, 2, 8'hFF, 8'hFF, 8'hFF);
      tick();
    end
    check("arm_fs_still_busy", {31'd0, busy_a}, 32'd1);
    send_frame(2'd3, 0, 1, 2'd3, lt, dt);
    check("arm_fs_count", {16'd0, cnt_a}, 32'd0);
    check("arm_fs_done", {31'd0, done_a}, 32'd1);

    // T2: single blue error at (7,3)
    arm(1'b0);
    send_frame(2'd0, 1, 1, 2'd0, lt, dt);
    check("t2_count", {16'd0, cnt_a}, 32'd1);
    check("t2_fev", {31'd0, fev_a}, 32'd1);
    check("t2_fx", {22'd0, fx_a}, 32'd7);
    check("t2_fy", {22'd0, fy_a}, 32'd3);
    check("t2_limit", {31'd0, lim_a}, 32'd0);
    check("t2_count_c", {28'd0, cnt_c}, 32'd1);

    // T3 / T6: inverted mode1 frame; dut_a stops at 7 pixels (21), dut_c saturates
    arm(1'b0);
    send_frame(2'd1, 2, 1, 2'd1, lt, dt);
    check("t3_limit", {31'd0, lim_a}, 32'd1);
    check("t3_count", {16'd0, cnt_a}, 32'd21);
    check("t3_fx", {22'd0, fx_a}, 32'd4);
    check("t3_fy", {22'd0, fy_a}, 32'd2);
    check("t3_done", {31'd0, done_a}, 32'd1);
    check("t3_done_within_2", {31'd0, (lt >= 0 && dt - lt >= 0 && dt - lt <= 2)}, 32'd1);
    check("t6_count_sat", {28'd0, cnt_c}, 32'd15);
    check("t6_limit_c", {31'd0, lim_c}, 32'd0);
    check("t6_done_c", {31'd0, done_c}, 32'd1);

    // T4: black mode2 frame on 1-pixel columns; per row popcounts of
    // c=0..7,0..3 sum to 16, six rows give 96.
    arm(1'b0);
    check("arm_clear_count", {16'd0, cnt_a}, 32'd0);
    check("arm_clear_limit", {31'd0, lim_a}, 32'd0);
    check("arm_clear_fev", {31'd0, fev_a}, 32'd0);
    check("arm_clear_done", {31'd0, done_a}, 32'd0);
    send_frame(2'd2, 3, 1, 2'd2, lt, dt);
    check("t4_count_b", {16'd0, cnt_b}, 32'd96);
    check("t4_limit_b", {31'd0, lim_b}, 32'd0);
    check("t4_done_b", {31'd0, done_b}, 32'd1);
    check("t4_fx_b", {22'd0, fx_b}, 32'd5);
    check("t4_fy_b", {22'd0, fy_b}, 32'd2);

    // T5: start ignored in CHECK, then reset mid-frame
    arm(1'b0);
    mode = 2'd0;
    pif.frame_start = 1'b1;
    tick();
    pif.frame_start = 1'b0;
    set_pix(1'b1, 4, 2, 8'hFF, 8'h00, 8'h00);
    tick();
    set_pix(1'b1, 5, 2, 8'h00, 8'h00, 8'h00);
    tick();
    pif.pixel_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t5_count", {16'd0, cnt_a}, 32'd1);
    check("t5_busy", {31'd0, busy_a}, 32'd1);
    check("t5_fx", {22'd0, fx_a}, 32'd4);
    rst = 1'b1;
    tick();
    check("t5_rst_busy", {31'd0, busy_a}, 32'd0);
    check("t5_rst_done", {31'd0, done_a}, 32'd0);
    check("t5_rst_count", {16'd0, cnt_a}, 32'd0);
    check("t5_rst_fev", {31'd0, fev_a}, 32'd0);
    check("t5_rst_fx", {22'd0, fx_a}, 32'd0);
    check("t5_rst_limit", {31'd0, lim_a}, 32'd0);
    rst = 1'b0;
    pif.frame_start = 1'b1;
    tick();
    pif.frame_start = 1'b0;
    set_pix(1'b1, 6, 2, 8'hFF, 8'hFF, 8'hFF);
    tick();
    pif.pixel_valid = 1'b0;
    tick();
    tick();
    check("t5_idle_count", {16'd0, cnt_a}, 32'd0);
    check("t5_idle_busy", {31'd0, busy_a}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
